ex_muldiv_unit: RTL

- Iterative multiply/divide unit with architectural HI/LO registers.
- Sits in the EX stage beside the ALU. It takes forwarded operands from the EX-stage forwarding muxes and serves MULT, MULTU, DIV, DIVU, MTHI, MTLO and the MFHI/MFLO reads.
- It stalls the pipeline while busy, and it can be generalised in data width and in bits retired per cycle.

---
 rtl/ex_pkg.sv | 21 ++
 rtl/muldiv_datapath.sv | 94 +++++++++
 rtl/ex_muldiv_unit.sv | 112 +++++++++++
 3 files changed

// File: rtl/ex_pkg.sv
// Shared definitions for the EX-stage multiply/divide unit: op codes and FSM states.
package ex_pkg;

  localparam int NB_MD_OP = 3;

  localparam logic [NB_MD_OP-1:0] MD_NOP   = 3'b000;
  localparam logic [NB_MD_OP-1:0] MD_MULT  = 3'b001;
  localparam logic [NB_MD_OP-1:0] MD_MULTU = 3'b010;
  localparam logic [NB_MD_OP-1:0] MD_DIV   = 3'b011;
  localparam logic [NB_MD_OP-1:0] MD_DIVU  = 3'b100;
  localparam logic [NB_MD_OP-1:0] MD_MTHI  = 3'b101;
  localparam logic [NB_MD_OP-1:0] MD_MTLO  = 3'b110;
  localparam logic [NB_MD_OP-1:0] MD_MADD  = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_FIX  = 2'd2
  } state_t;

endpackage

// File: rtl/muldiv_datapath.sv
// Iterative magnitude datapath: shift-add multiply / restoring divide, STEP bits per
// cycle, plus the combinational sign-fix stage that produces the HI/LO results.
module muldiv_datapath #(
  parameter int NB_DATA = 32,
  parameter int STEP    = 1
) (
  input  logic               clk_i,
  input  logic               rst_n_i,
  input  logic               load_i,
  input  logic               calc_i,
  input  logic               is_div_i,
  input  logic               is_signed_i,
  input  logic [NB_DATA-1:0] a_i,
  input  logic [NB_DATA-1:0] b_i,
  output logic [NB_DATA-1:0] res_hi_o,
  output logic [NB_DATA-1:0] res_lo_o
);

  logic [NB_DATA-1:0]   acc_hi, acc_lo, opnd, a_raw;
  logic [NB_DATA-1:0]   step_hi, step_lo, mag_a, mag_b, quo, rem;
  logic                 is_div, neg_main, neg_rem, div_zero, sign_a, sign_b;
  logic [NB_DATA:0]     shifted, sum;
  logic [NB_DATA+1:0]   trial;
  logic [2*NB_DATA-1:0] prod;

  assign sign_a = is_signed_i & a_i[NB_DATA-1];
  assign sign_b = is_signed_i & b_i[NB_DATA-1];
  assign mag_a  = sign_a ? -a_i : a_i;
  assign mag_b  = sign_b ? -b_i : b_i;

  // acc_hi/acc_lo hold {product high, multiplier} for multiply and {remainder, quotient} for divide
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      acc_hi   <= '0;
      acc_lo   <= '0;
      opnd     <= '0;
      a_raw    <= '0;
      is_div   <= 1'b0;
      neg_main <= 1'b0;
      neg_rem  <= 1'b0;
      div_zero <= 1'b0;
    end else if (load_i) begin
      acc_hi   <= '0;
      acc_lo   <= is_div_i ? mag_a : mag_b;
      opnd     <= is_div_i ? mag_b : mag_a;
      a_raw    <= a_i;
      is_div   <= is_div_i;
      neg_main <= sign_a ^ sign_b;
      neg_rem  <= sign_a;
      div_zero <= is_div_i & (b_i == '0);
    end else if (calc_i) begin
      acc_hi <= step_hi;
      acc_lo <= step_lo;
    end
  end

  always_comb begin
    step_hi = acc_hi;
    step_lo = acc_lo;
    shifted = '0;
    trial   = '0;
    sum     = '0;
    for (int unsigned i = 0; i < STEP; i++) begin
      if (is_div) begin
        shifted = {step_hi, step_lo[NB_DATA-1]};
        trial   = {1'b0, shifted} - {2'b00, opnd};
        step_lo = {step_lo[NB_DATA-2:0], ~trial[NB_DATA+1]};
        step_hi = trial[NB_DATA+1] ? shifted[NB_DATA-1:0] : trial[NB_DATA-1:0];
      end else begin
        sum     = {1'b0, step_hi} + (step_lo[0] ? {1'b0, opnd} : '0);
        step_lo = {sum[0], step_lo[NB_DATA-1:1]};
        step_hi = sum[NB_DATA:1];
      end
    end
  end

  assign prod = neg_main ? -{acc_hi, acc_lo} : {acc_hi, acc_lo};
  assign quo  = neg_main ? -acc_lo : acc_lo;
  assign rem  = neg_rem  ? -acc_hi : acc_hi;

  always_comb begin
    {res_hi_o, res_lo_o} = prod;
    if (is_div) begin
      if (div_zero) begin
        res_hi_o = a_raw;
        res_lo_o = '1;
      end else begin
        res_hi_o = rem;
        res_lo_o = quo;
      end
    end
  end

endmodule

// File: rtl/ex_muldiv_unit.sv
// EX-stage multiply/divide unit with HI/LO registers, busy/stall and flush handling.
// Optional MADD accumulate (op 111) is enabled by defining MULDIV_MADD_EN.
module ex_muldiv_unit #(
  parameter int NB_DATA  = 32,
  parameter int NB_MD_OP = 3,
  parameter int STEP     = 1
) (
  input  logic                clk_i,
  input  logic                rst_n_i,
  input  logic                start_i,
  input  logic [NB_MD_OP-1:0] md_op_i,
  input  logic [NB_DATA-1:0]  data_a_i,
  input  logic [NB_DATA-1:0]  data_b_i,
  input  logic                rd_hilo_i,
  input  logic                flush_i,
  output logic [NB_DATA-1:0]  hi_o,
  output logic [NB_DATA-1:0]  lo_o,
  output logic                busy_o,
  output logic                stall_o,
  output logic                done_o
);
  import ex_pkg::*;

  localparam int unsigned ITERS = NB_DATA / STEP;
  localparam int          CNT_W = $clog2(ITERS + 1);

  state_t               state, state_nx;
  logic [CNT_W-1:0]     cnt;
  logic [NB_DATA-1:0]   hi_q, lo_q, res_hi, res_lo;
  logic [2*NB_DATA-1:0] wb;
  logic                 start_ok, accept, md_madd;

  assign start_ok = (state == ST_IDLE) & start_i & ~flush_i;

`ifdef MULDIV_MADD_EN
  logic madd_q;

  assign md_madd = (md_op_i == MD_MADD);
  assign wb      = madd_q ? ({hi_q, lo_q} + {res_hi, res_lo}) : {res_hi, res_lo};

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i)    madd_q <= 1'b0;
    else if (accept) madd_q <= md_madd;
  end
`else
  assign md_madd = 1'b0;
  assign wb      = {res_hi, res_lo};
`endif

  assign accept = start_ok & ((md_op_i == MD_MULT) | (md_op_i == MD_MULTU) |
                              (md_op_i == MD_DIV)  | (md_op_i == MD_DIVU) | md_madd);

  muldiv_datapath #(
    .NB_DATA (NB_DATA),
    .STEP    (STEP)
  ) u_datapath (
    .clk_i       (clk_i),
    .rst_n_i     (rst_n_i),
    .load_i      (accept),
    .calc_i      (state == ST_CALC),
    .is_div_i    ((md_op_i == MD_DIV) | (md_op_i == MD_DIVU)),
    .is_signed_i ((md_op_i == MD_MULT) | (md_op_i == MD_DIV) | md_madd),
    .a_i         (data_a_i),
    .b_i         (data_b_i),
    .res_hi_o    (res_hi),
    .res_lo_o    (res_lo)
  );

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) state <= ST_IDLE;
    else          state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE: if (accept) state_nx = ST_CALC;
      ST_CALC: begin
        if (flush_i)                 state_nx = ST_IDLE;
        else if (cnt == CNT_W'(1))   state_nx = ST_FIX;
      end
      ST_FIX:  state_nx = ST_IDLE;
      default: state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i)               cnt <= '0;
    else if (accept)            cnt <= CNT_W'(ITERS);
    else if (state == ST_CALC)  cnt <= cnt - CNT_W'(1);
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      hi_q <= '0;
      lo_q <= '0;
    end else if (state == ST_FIX && !flush_i) begin
      {hi_q, lo_q} <= wb;
    end else if (start_ok && md_op_i == MD_MTHI) begin
      hi_q <= data_a_i;
    end else if (start_ok && md_op_i == MD_MTLO) begin
      lo_q <= data_a_i;
    end
  end

  assign hi_o    = hi_q;
  assign lo_o    = lo_q;
  assign busy_o  = (state != ST_IDLE);
  assign stall_o = busy_o & (start_i | rd_hilo_i);
  assign done_o  = (state == ST_FIX) & ~flush_i;

endmodule
